// File: rtl/reg_file.sv
// Multi-port two-phase register file with LC-3 NZP condition codes: capture on posedge, commit on negedge.
// Optional read-after-write forwarding during clk high when REG_FILE_BYPASS_EN is defined.
module reg_file_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] stg,
    output logic [WIDTH-1:0] cmt
);
    always_ff @(posedge clk) begin
        if (rst)
            stg <= '0;
        else if (we)
            stg <= d;
    end

    always_ff @(negedge clk) begin
        cmt <= stg;
    end
endmodule

module reg_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              cc_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic [2:0]        cc_out
);
    logic [DEPTH-1:0][WIDTH-1:0] stg;
    logic [DEPTH-1:0][WIDTH-1:0] cmt;
    logic [2:0] stg_cc;
    logic [2:0] cmt_cc;
    logic [2:0] cc_next;

    // Addresses >= DEPTH match no cell, so such writes drop out naturally.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        reg_file_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .rst (rst),
            .we  (wr_en && (wr_addr == ADDR_W'(i))),
            .d   (wr_data),
            .stg (stg[i]),
            .cmt (cmt[i])
        );
    end

    always_comb begin
        cc_next = 3'b001;
        if (wr_data[WIDTH-1])
            cc_next = 3'b100;
        else if (wr_data == '0)
            cc_next = 3'b010;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stg_cc <= 3'b010;
        else if (cc_en)
            stg_cc <= cc_next;
    end

    always_ff @(negedge clk) begin
        cmt_cc <= stg_cc;
    end

`ifdef REG_FILE_BYPASS_EN
    // Remember what the last posedge captured so clk-high reads can forward it.
    logic              pend_wr;
    logic              pend_cc;
    logic [ADDR_W-1:0] pend_addr;
    logic [WIDTH-1:0]  pend_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wr <= 1'b0;
            pend_cc <= 1'b0;
        end else begin
            pend_wr <= wr_en && (32'(wr_addr) < DEPTH);
            pend_cc <= cc_en;
        end
        pend_addr <= wr_addr;
        pend_data <= wr_data;
    end
`endif

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        cc_out    = cmt_cc;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i))
                rd_data_a = cmt[i];
            if (rd_addr_b == ADDR_W'(i))
                rd_data_b = cmt[i];
        end
`ifdef REG_FILE_BYPASS_EN
        if (clk && pend_wr && (rd_addr_a == pend_addr))
            rd_data_a = pend_data;
        if (clk && pend_wr && (rd_addr_b == pend_addr))
            rd_data_b = pend_data;
        if (clk && pend_cc)
            cc_out = stg_cc;
`endif
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: event-level model checked every half cycle, plus literal spot checks.
module tb_reg_file;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, cc_en = 1'b0;
    logic [2:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data_a, rd_data_b;
    logic [2:0]  cc_out;

    // DEPTH=6 instance
    logic        d_wr_en = 1'b0, d_cc_en = 1'b0;
    logic [2:0]  d_wr_addr = '0, d_rda = '0, d_rdb = '0;
    logic [15:0] d_wr_data = '0, d_outa, d_outb;
    logic [2:0]  d_cc;

    // WIDTH=32 instance
    logic        w_wr_en = 1'b0, w_cc_en = 1'b0;
    logic [2:0]  w_wr_addr = '0, w_rda = '0, w_rdb = '0;
    logic [31:0] w_wr_data = '0, w_outa, w_outb;
    logic [2:0]  w_cc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cc_en(cc_en), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .cc_out(cc_out)
    );

    reg_file #(.WIDTH(16), .DEPTH(6)) dut_d6 (
        .clk(clk), .rst(rst), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
        .cc_en(d_cc_en), .rd_addr_a(d_rda), .rd_data_a(d_outa),
        .rd_addr_b(d_rdb), .rd_data_b(d_outb), .cc_out(d_cc)
    );

    reg_file #(.WIDTH(32), .DEPTH(8)) dut_w32 (
        .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .cc_en(w_cc_en), .rd_addr_a(w_rda), .rd_data_a(w_outa),
        .rd_addr_b(w_rdb), .rd_data_b(w_outb), .cc_out(w_cc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a posedge records an event, the following negedge makes it architecturally visible.
    logic [15:0] m_mem [8];
    logic [2:0]  m_cc;
    bit          m_ok = 1'b0;
    bit          p_rst = 1'b0, p_wr = 1'b0, p_cc = 1'b0;
    logic [2:0]  p_addr, p_ccv;
    logic [15:0] p_data;

    function automatic logic [2:0] nzp(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        if (BYP && clk && p_wr && p_addr == a) return p_data;
        return m_mem[a];
    endfunction

    function automatic logic [2:0] exp_cc();
        if (BYP && clk && p_cc) return p_ccv;
        return m_cc;
    endfunction

    always @(posedge clk) begin
        p_rst  <= rst;
        p_wr   <= !rst && wr_en;
        p_cc   <= !rst && cc_en;
        p_addr <= wr_addr;
        p_data <= wr_data;
        p_ccv  <= nzp(wr_data);
    end

    always @(negedge clk) begin
        if (p_rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] <= '0;
            m_cc <= 3'b010;
            m_ok <= 1'b1;
        end else begin
            if (p_wr) m_mem[p_addr] <= p_data;
            if (p_cc) m_cc <= p_ccv;
        end
    end

    always begin
        @(clk);
        #2;
        if (m_ok) begin
            chk("model_rd_a", 32'(rd_data_a), 32'(exp_rd(rd_addr_a)));
            chk("model_rd_b", 32'(rd_data_b), 32'(exp_rd(rd_addr_b)));
            chk("model_cc", 32'(cc_out), 32'(exp_cc()));
        end
    end

    task automatic hi();
        @(posedge clk);
        #2;
    endtask

    task automatic lo();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    initial begin
        // Reset with a competing write to R3 that must be lost.
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        lo();
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            chk("rst_rd_a", 32'(rd_data_a), 32'h0);
            chk("rst_rd_b", 32'(rd_data_b), 32'h0);
        end
        chk("rst_cc", 32'(cc_out), 32'b010);
        chk("rst_d6_cc", 32'(d_cc), 32'b010);
        chk("rst_w32_a", w_outa, 32'h0);
        lo();

        // Write and dual read
        rd_addr_a = 3'd2; rd_addr_b = 3'd5;
        wr(3'd2, 16'h1234);
        hi(); chk("wr1_hi_a", 32'(rd_data_a), BYP ? 32'h1234 : 32'h0);
        lo(); chk("wr1_lo_a", 32'(rd_data_a), 32'h1234);
        chk("wr1_lo_b", 32'(rd_data_b), 32'h0);
        wr(3'd5, 16'hFFFF);
        hi(); chk("wr2_hi_b", 32'(rd_data_b), BYP ? 32'hFFFF : 32'h0);
        lo(); chk("wr2_lo_b", 32'(rd_data_b), 32'hFFFF);
        chk("wr2_lo_a", 32'(rd_data_a), 32'h1234);
        wr_en = 1'b0;

        // Condition codes
        cc_en = 1'b1; wr_data = 16'h8000;
        lo(); chk("cc_neg", 32'(cc_out), 32'b100);
        wr_data = 16'h0000;
        lo(); chk("cc_zero", 32'(cc_out), 32'b010);
        wr_data = 16'h0001;
        lo(); chk("cc_pos", 32'(cc_out), 32'b001);
        cc_en = 1'b0; wr_data = 16'h8000;
        lo(); chk("cc_hold", 32'(cc_out), 32'b001);

        // Same-address hazard and back-to-back writes
        rd_addr_a = 3'd4;
        wr(3'd4, 16'h0055);
        lo();
        wr(3'd4, 16'h00AA);
        hi(); chk("haz_hi", 32'(rd_data_a), BYP ? 32'h00AA : 32'h0055);
        lo(); chk("haz_lo", 32'(rd_data_a), 32'h00AA);
        wr_en = 1'b0;

        // Reset in the middle of a burst to R1
        rd_addr_a = 3'd1; rd_addr_b = 3'd4;
        wr(3'd1, 16'h0011); lo();
        wr(3'd1, 16'h0022); lo();
        chk("burst_pre", 32'(rd_data_a), 32'h0022);
        wr(3'd1, 16'h0033); rst = 1'b1;
        lo();
        chk("mid_rst_r1", 32'(rd_data_a), 32'h0);
        chk("mid_rst_r4", 32'(rd_data_b), 32'h0);
        rst = 1'b0; wr(3'd1, 16'h0077);
        hi(); chk("post_rst_hi", 32'(rd_data_a), BYP ? 32'h0077 : 32'h0);
        lo(); chk("post_rst_lo", 32'(rd_data_a), 32'h0077);

        // Directed mix for the model compare
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'(16'h1111 * (i + 1)));
            cc_en = i[0];
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            lo();
        end
        wr_en = 1'b0; cc_en = 1'b0;
        rd_addr_a = 3'd7; rd_addr_b = 3'd0;
        lo();
        chk("mix_r7", 32'(rd_data_a), 32'h8888);
        chk("mix_r0", 32'(rd_data_b), 32'h1111);
        chk("mix_cc", 32'(cc_out), 32'b100);

        // DEPTH=6: out-of-range write dropped, out-of-range read is zero
        d_wr_en = 1'b1; d_wr_addr = 3'd7; d_wr_data = 16'hAAAA; d_rda = 3'd7; d_rdb = 3'd5;
        lo();
        chk("d6_rd7", 32'(d_outa), 32'h0);
        chk("d6_r5_untouched", 32'(d_outb), 32'h0);
        d_wr_addr = 3'd5; d_wr_data = 16'h1111;
        lo();
        chk("d6_r5_write", 32'(d_outb), 32'h1111);
        chk("d6_rd7_again", 32'(d_outa), 32'h0);
        d_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_rdb = 3'(i);
            #1;
            chk("d6_others", 32'(d_outb), 32'h0);
        end

        // WIDTH=32: sign bit drives N
        lo();
        w_wr_en = 1'b1; w_wr_addr = 3'd0; w_wr_data = 32'h8000_0000; w_cc_en = 1'b1; w_rda = 3'd0;
        lo();
        chk("w32_n", 32'(w_cc), 32'b100);
        chk("w32_data", w_outa, 32'h8000_0000);
        w_wr_en = 1'b0; w_wr_data = 32'h0000_0000;
        lo();
        chk("w32_z", 32'(w_cc), 32'b010);
        w_cc_en = 1'b0;
        lo();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
